// File: rtl/clk_en_gen_pkg.sv
// clk_en_gen_pkg: shared types and helpers for the fractional clock-enable generator.
package clk_en_gen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Channel-select width; a single channel still gets a one-bit select port.
    function automatic int ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    // A ratio is usable when inc/mod is a proper fraction in (0, 1] on an existing channel.
    function automatic logic cfg_valid(input logic [31:0] inc,
                                       input logic [31:0] modv,
                                       input logic [31:0] ch,
                                       input logic [31:0] nch);
        return (modv != 32'd0) && (inc != 32'd0) && (inc <= modv) && (ch < nch);
    endfunction

endpackage

// File: rtl/clk_en_acc.sv
// clk_en_acc: one fractional-rate channel. Phase accumulator plus its own
// inc/mod registers; a pending new ratio is swapped in on the channel's next
// wrap (or immediately when not running) so the strobe train never glitches.
module clk_en_acc #(
    parameter int               ACC_W    = 16,
    parameter logic [ACC_W-1:0] INIT_INC = 16'd1,
    parameter logic [ACC_W-1:0] INIT_MOD = 16'd3
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             i_run,
    input  logic             i_clr,
    input  logic             i_pend,
    input  logic [ACC_W-1:0] i_new_inc,
    input  logic [ACC_W-1:0] i_new_mod,
    output logic             o_apply,
    output logic             o_ce
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_mod;
    logic             r_ce;
    logic [ACC_W:0]   w_sum;
    logic             w_wrap;

    // One extra bit so acc + inc never overflows before the modulus compare.
    assign w_sum   = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_wrap  = (w_sum >= {1'b0, r_mod});
    // A resync cycle is not a strobe cycle, so a pending ratio waits for the next real wrap.
    assign o_apply = i_pend && (!i_run || (w_wrap && !i_clr));
    assign o_ce    = r_ce;

    // Accumulate in RUN, clear otherwise; load the new ratio on the apply cycle.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
            r_inc <= INIT_INC;
            r_mod <= INIT_MOD;
            r_ce  <= 1'b0;
        end else begin
            if (!i_run || i_clr) begin
                r_acc <= '0;
                r_ce  <= 1'b0;
            end else if (w_wrap) begin
                r_ce  <= 1'b1;
                r_acc <= o_apply ? '0 : ACC_W'(w_sum - {1'b0, r_mod});
            end else begin
                r_ce  <= 1'b0;
                r_acc <= w_sum[ACC_W-1:0];
            end
            if (o_apply) begin
                r_inc <= i_new_inc;
                r_mod <= i_new_mod;
            end
        end
    end

endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: NCH fractional clock-enable strobes behind the PLL, with lock
// qualification, downstream reset sequencing and req/ack ratio reprogramming.
// Optional build macro CLK_EN_GEN_RESYNC_EN adds the resync input that
// phase-aligns all channels while running.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int                     NCH       = 2,
    parameter int                     ACC_W     = 16,
    parameter int                     LOCK_HOLD = 255,
    parameter logic [NCH*ACC_W-1:0]   INIT_INC  = {16'd1, 16'd1},
    parameter logic [NCH*ACC_W-1:0]   INIT_MOD  = {16'd3, 16'd54},
    localparam int                    CH_W      = ch_w(NCH)
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic             pll_lock,
    input  logic             cfg_req,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic [ACC_W-1:0] cfg_mod,
`ifdef CLK_EN_GEN_RESYNC_EN
    input  logic             resync,
`endif
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic [NCH-1:0]   ce,
    output logic             run,
    output logic             rst_out
);

    localparam logic [16:0] HOLD_TGT = 17'(LOCK_HOLD - 1);

    state_t           r_state;
    logic [16:0]      r_hold;
    logic             r_run;
    logic             r_rst_out;
    logic             r_busy;
    logic             r_armed;
    logic             r_ack;
    logic             r_err;
    logic [CH_W-1:0]  r_ch;
    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_mod;

    logic [16:0]      w_hold_nxt;
    logic             w_run_en;
    logic             w_clr;
    logic             w_accept;
    logic             w_valid;
    logic [NCH-1:0]   w_apply;
    logic [NCH-1:0]   w_ce;

    assign w_hold_nxt = r_hold + 17'd1;
    // Channels stop in the very cycle lock drops, so the clear lands with run falling.
    assign w_run_en   = (r_state == RUN) && pll_lock;
`ifdef CLK_EN_GEN_RESYNC_EN
    assign w_clr      = resync && (r_state == RUN);
`else
    assign w_clr      = 1'b0;
`endif
    assign w_accept   = cfg_req && r_armed && !r_busy;
    assign w_valid    = cfg_valid(32'(cfg_inc), 32'(cfg_mod), 32'(cfg_ch), 32'(NCH));

    // Lock qualification FSM; run/rst_out are registered and always toggle together.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_state   <= WAIT_LOCK;
            r_hold    <= '0;
            r_run     <= 1'b0;
            r_rst_out <= 1'b1;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    if (pll_lock) begin
                        r_hold  <= '0;
                        r_state <= STABLE;
                    end
                end
                STABLE: begin
                    if (!pll_lock) begin
                        r_state <= WAIT_LOCK;
                    end else if (w_hold_nxt >= HOLD_TGT) begin
                        r_state   <= RUN;
                        r_run     <= 1'b1;
                        r_rst_out <= 1'b0;
                    end else begin
                        r_hold <= w_hold_nxt;
                    end
                end
                RUN: begin
                    if (!pll_lock) begin
                        r_state   <= WAIT_LOCK;
                        r_run     <= 1'b0;
                        r_rst_out <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= WAIT_LOCK;
                    r_run     <= 1'b0;
                    r_rst_out <= 1'b1;
                end
            endcase
        end
    end

    // Config handshake: accept once per req-low/high cycle, reject at once or ack when applied.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_busy  <= 1'b0;
            r_armed <= 1'b1;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_ch    <= '0;
            r_inc   <= '0;
            r_mod   <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (w_accept) begin
                r_armed <= 1'b0;
                if (w_valid) begin
                    r_busy <= 1'b1;
                    r_ch   <= cfg_ch;
                    r_inc  <= cfg_inc;
                    r_mod  <= cfg_mod;
                end else begin
                    r_ack <= 1'b1;
                    r_err <= 1'b1;
                end
            end else begin
                if (!cfg_req && !r_busy) begin
                    r_armed <= 1'b1;
                end
                if (|w_apply) begin
                    r_busy <= 1'b0;
                    r_ack  <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_en_acc #(
            .ACC_W    (ACC_W),
            .INIT_INC (INIT_INC[g*ACC_W +: ACC_W]),
            .INIT_MOD (INIT_MOD[g*ACC_W +: ACC_W])
        ) u_acc (
            .clkin     (clkin),
            .reset     (reset),
            .i_run     (w_run_en),
            .i_clr     (w_clr),
            .i_pend    (r_busy && (r_ch == CH_W'(g))),
            .i_new_inc (r_inc),
            .i_new_mod (r_mod),
            .o_apply   (w_apply[g]),
            .o_ce      (w_ce[g])
        );
    end

    assign ce      = w_ce;
    assign run     = r_run;
    assign rst_out = r_rst_out;
    assign cfg_ack = r_ack;
    assign cfg_err = r_err;

endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed table vectors for lock qualification and strobe
// patterns, plus hand-written sequences for the config handshake corners.
module tb_clk_en_gen;

    localparam int NCH       = 2;
    localparam int ACC_W     = 16;
    localparam int LOCK_HOLD = 4;

    logic             clkin    = 1'b0;
    logic             reset    = 1'b1;
    logic             pll_lock = 1'b0;
    logic             cfg_req  = 1'b0;
    logic [0:0]       cfg_ch   = 1'b0;
    logic [ACC_W-1:0] cfg_inc  = '0;
    logic [ACC_W-1:0] cfg_mod  = '0;
`ifdef CLK_EN_GEN_RESYNC_EN
    logic             resync   = 1'b0;
`endif
    logic             cfg_ack;
    logic             cfg_err;
    logic [NCH-1:0]   ce;
    logic             run;
    logic             rst_out;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        bit         rst;
        bit         lock;
        bit         exp_run;
        logic [1:0] exp_ce;
    } vec_t;

    vec_t tbl[$];

    always #5 clkin = ~clkin;

    clk_en_gen #(
        .NCH       (NCH),
        .ACC_W     (ACC_W),
        .LOCK_HOLD (LOCK_HOLD),
        .INIT_INC  ({16'd2, 16'd1}),
        .INIT_MOD  ({16'd5, 16'd3})
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .pll_lock (pll_lock),
        .cfg_req  (cfg_req),
        .cfg_ch   (cfg_ch),
        .cfg_inc  (cfg_inc),
        .cfg_mod  (cfg_mod),
`ifdef CLK_EN_GEN_RESYNC_EN
        .resync   (resync),
`endif
        .cfg_ack  (cfg_ack),
        .cfg_err  (cfg_err),
        .ce       (ce),
        .run      (run),
        .rst_out  (rst_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        pll_lock = 1'b0;
        cfg_req  = 1'b0;
        repeat (2) @(posedge clkin);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic wait_ack(input int lim, output bit got);
        got = 1'b0;
        for (int i = 0; i < lim; i++) begin
            step();
            if (cfg_ack) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    function automatic void add(bit r, bit l, bit er, logic [1:0] ec);
        tbl.push_back('{rst: r, lock: l, exp_run: er, exp_ce: ec});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        int cnt0;
        int cnt1;
        int t0;

        // Glitch sequence: lock 10,11, low at 12, high from 13 -> run from 17.
        for (int k = 0; k <= 18; k++) add(k == 0, (k >= 10) && (k != 12), k >= 17, 2'b00);
        // Clean sequence: lock from 10 -> run from 14, then ch0 1/3 and ch1 2/5.
        for (int k = 0; k <= 13; k++) add(k == 0, k >= 10, 1'b0, 2'b00);
        add(0, 1, 1, 2'b00);  // 14
        add(0, 1, 1, 2'b00);  // 15
        add(0, 1, 1, 2'b00);  // 16
        add(0, 1, 1, 2'b11);  // 17
        add(0, 1, 1, 2'b00);  // 18
        add(0, 1, 1, 2'b10);  // 19
        add(0, 1, 1, 2'b01);  // 20
        add(0, 1, 1, 2'b00);  // 21
        add(0, 1, 1, 2'b10);  // 22
        add(0, 1, 1, 2'b01);  // 23
        add(0, 1, 1, 2'b10);  // 24

        foreach (tbl[i]) begin
            if (tbl[i].rst) begin
                do_reset();
                chk("rst_ack", 32'(cfg_ack), 32'd0);
                chk("rst_err", 32'(cfg_err), 32'd0);
            end
            chk("run", 32'(run), 32'(tbl[i].exp_run));
            chk("rst_out", 32'(rst_out), 32'(!tbl[i].exp_run));
            chk("ce", 32'(ce), 32'(tbl[i].exp_ce));
            pll_lock = tbl[i].lock;
            step();
        end

        // cycle 25: invalid request inc=7 mod=5 on ch0.
        cfg_req = 1'b1; cfg_ch = 1'b0; cfg_inc = 16'd7; cfg_mod = 16'd5;
        step();
        chk("inv_ack", 32'(cfg_ack), 32'd1);
        chk("inv_err", 32'(cfg_err), 32'd1);
        chk("inv_ce0", 32'(ce[0]), 32'd1);
        // req held high: no second ack, ch0 keeps 1/3 (strobes on cyc%3==2).
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_no_ack", 32'(cfg_ack), 32'd0);
            chk("hold_err", 32'(cfg_err), 32'd0);
            chk("inv_ratio_ce0", 32'(ce[0]), 32'(cyc % 3 == 2));
        end
        cfg_req = 1'b0;
        step();
        chk("ce0_c32", 32'(ce[0]), 32'd1);

        // cycle 32: reprogram ch0 to 1023/54000 in RUN; applies on the wrap shown at 35.
        cfg_req = 1'b1; cfg_ch = 1'b0; cfg_inc = 16'd1023; cfg_mod = 16'd54000;
        wait_ack(8, got);
        chk("reprog_ack_seen", 32'(got), 32'd1);
        chk("reprog_ack_cyc", 32'(cyc), 32'd35);
        chk("reprog_err", 32'(cfg_err), 32'd0);
        chk("reprog_strobe", 32'(ce[0]), 32'd1);
        cfg_req = 1'b0;
        cnt0 = 0;
        cnt1 = 0;
        repeat (54000) begin
            step();
            cnt0 += int'(ce[0]);
            cnt1 += int'(ce[1]);
        end
        chk("strobes_1023", 32'(cnt0), 32'd1023);
        chk("strobes_ch1", 32'(cnt1), 32'd21600);

        // Pending ch0 -> 1/2, then lock drops before the next wrap.
        cfg_req = 1'b1; cfg_ch = 1'b0; cfg_inc = 16'd1; cfg_mod = 16'd2;
        step();
        step();
        chk("pend_no_ack", 32'(cfg_ack), 32'd0);
        pll_lock = 1'b0;
        t0 = cyc;
        step();
        chk("drop_run", 32'(run), 32'd0);
        chk("drop_rst_out", 32'(rst_out), 32'd1);
        chk("drop_ce", 32'(ce), 32'd0);
        got = cfg_ack;
        if (!got) wait_ack(1, got);
        chk("drop_ack_seen", 32'(got), 32'd1);
        chk("drop_ack_err", 32'(cfg_err), 32'd0);
        chk("drop_ack_within2", 32'(cyc - t0 <= 2), 32'd1);
        cfg_req = 1'b0;

        // Relock: run rises 4 cycles after lock is seen, new ch0 ratio in use.
        pll_lock = 1'b1;
        t0 = cyc;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (run) begin
                got = 1'b1;
                break;
            end
        end
        chk("relock_run", 32'(got), 32'd1);
        chk("relock_delay", 32'(cyc - t0), 32'd4);
        chk("relock_ce_r0", 32'(ce), 32'b00);
        step();
        chk("relock_ce_r1", 32'(ce), 32'b00);
        step();
        chk("relock_ce_r2", 32'(ce), 32'b01);
        step();
        chk("relock_ce_r3", 32'(ce), 32'b10);
        step();
        chk("relock_ce_r4", 32'(ce), 32'b01);
        step();
        chk("relock_ce_r5", 32'(ce), 32'b10);
        step();

`ifdef CLK_EN_GEN_RESYNC_EN
        // Resync pulse: both channels restart from acc=0.
        resync = 1'b1;
        step();
        resync = 1'b0;
        chk("resync_ce_p1", 32'(ce), 32'b00);
        step();
        chk("resync_ce_p2", 32'(ce), 32'b00);
        step();
        chk("resync_ce_p3", 32'(ce), 32'b01);
        step();
        chk("resync_ce_p4", 32'(ce), 32'b10);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
